// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the iteration counter width.
package mdu_pkg;
   localparam int MDU_N     = 32;
   localparam int MDU_CNT_W = $clog2(MDU_N);

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ITER  = 2'd1,
      ST_FIXUP = 2'd2
   } mdu_state_e;

   function automatic logic mdu_is_div(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic mdu_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction
endpackage

// File: rtl/mdu_cond_neg.sv
// W-bit conditional two's-complement negate: out = neg ? -in : in.
module mdu_cond_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] in_i,
   input  logic         neg_i,
   output logic [W-1:0] out_o
);
   assign out_o = neg_i ? (~in_i + W'(1)) : in_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers, one result bit per cycle.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete at once with HI/LO untouched.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int N = MDU_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [1:0]   op_i,
   input  logic [N-1:0] rs_data_i,
   input  logic [N-1:0] rt_data_i,
   input  logic         hi_we_i,
   input  logic         lo_we_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] hi_o,
   output logic [N-1:0] lo_o,
   output logic [1:0]   dbg_state_o
);
   localparam int CW = (N == MDU_N) ? MDU_CNT_W : $clog2(N);

   mdu_state_e     state_q, state_d;
   mdu_op_e        op_q, op_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic [N-1:0]   m_q, m_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           done_q, done_d;

   mdu_op_e        op_in;
   logic           in_signed;
   logic [N-1:0]   rs_mag, rt_mag;
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_next, prod_fix;

   assign op_in     = mdu_op_e'(op_i);
   assign in_signed = mdu_is_signed(op_in);

   mdu_cond_neg #(.W(N)) u_rs_mag (
      .in_i (rs_data_i),
      .neg_i(in_signed & rs_data_i[N-1]),
      .out_o(rs_mag)
   );

   mdu_cond_neg #(.W(N)) u_rt_mag (
      .in_i (rt_data_i),
      .neg_i(in_signed & rt_data_i[N-1]),
      .out_o(rt_mag)
   );

   mdu_cond_neg #(.W(2*N)) u_prod_fix (
      .in_i (acc_q),
      .neg_i(mdu_is_signed(op_q) & (sa_q ^ sb_q)),
      .out_o(prod_fix)
   );

   // Multiply: acc = {partial, multiplier}; add multiplicand on the low bit, shift right with carry.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
      mul_next = {mul_sum, acc_q[N-1:1]};
   end

`ifdef MDU_DIV_EN
   logic [N-1:0]   rs_q, rs_d;
   logic [N:0]     div_rem, div_diff;
   logic [2*N-1:0] div_next;
   logic [N-1:0]   quo_fix, rem_fix;

   // Divide: acc = {remainder, dividend/quotient}; shift left, keep the subtraction if no borrow.
   always_comb begin
      div_rem  = {acc_q[2*N-1:N], acc_q[N-1]};
      div_diff = div_rem - {1'b0, m_q};
      if (div_diff[N]) div_next = {div_rem[N-1:0], acc_q[N-2:0], 1'b0};
      else             div_next = {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
   end

   mdu_cond_neg #(.W(N)) u_quo_fix (
      .in_i (acc_q[N-1:0]),
      .neg_i(mdu_is_signed(op_q) & (sa_q ^ sb_q)),
      .out_o(quo_fix)
   );

   mdu_cond_neg #(.W(N)) u_rem_fix (
      .in_i (acc_q[2*N-1:N]),
      .neg_i(mdu_is_signed(op_q) & sa_q),
      .out_o(rem_fix)
   );

   always_ff @(posedge clk) begin
      if (reset) rs_q <= '0;
      else       rs_q <= rs_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      m_d     = m_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MDU_DIV_EN
      rs_d    = rs_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               op_d  = op_in;
               sa_d  = in_signed & rs_data_i[N-1];
               sb_d  = in_signed & rt_data_i[N-1];
               cnt_d = '0;
               if (mdu_is_div(op_in)) begin
`ifdef MDU_DIV_EN
                  m_d     = rt_mag;
                  acc_d   = {{N{1'b0}}, rs_mag};
                  rs_d    = rs_data_i;
                  state_d = ST_ITER;
`else
                  state_d = ST_FIXUP;
`endif
               end else begin
                  m_d     = rs_mag;
                  acc_d   = {{N{1'b0}}, rt_mag};
                  state_d = ST_ITER;
               end
            end else begin
               // start takes priority over MTHI/MTLO in the same cycle
               if (hi_we_i) hi_d = rs_data_i;
               if (lo_we_i) lo_d = rs_data_i;
            end
         end
         ST_ITER: begin
`ifdef MDU_DIV_EN
            acc_d = mdu_is_div(op_q) ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) begin
               cnt_d   = '0;
               state_d = ST_FIXUP;
            end
         end
         ST_FIXUP: begin
            if (!mdu_is_div(op_q)) {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
            else if (m_q == '0) begin
               hi_d = rs_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
`endif
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= MDU_MULT;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         m_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;
   assign dbg_state_o = state_q;
endmodule
